// File: rtl/kernel3_gmem_a_m_axi_srl_fifo.sv
// Show-ahead FIFO for the gmem_A m_axi adapter.
// A shift-register store holds DEPTH-1 words; one output register holds the
// head word so that if_dout comes straight from a flop. The controller keeps
// the store occupancy and refills the output register from the oldest entry.

module kernel3_gmem_a_m_axi_srl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 63
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH-1];

    // Shift storage: new word enters entry 0, older words move up; never reset
    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int i = DEPTH - 2; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
            mem[0] <= din;
        end
    end

    // Registered read of the pre-shift array, so a same-edge shift cannot disturb it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (rd_en) begin
            q <= mem[rd_addr];
        end
    end

endmodule

module kernel3_gmem_a_m_axi_srl_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 63
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clk_en,
    output logic                  if_full_n,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_num_data_valid
);

    localparam logic [ADDR_WIDTH-1:0] USED_MAX = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] used;
    logic [ADDR_WIDTH-1:0] used_next;
    logic                  dout_vld;
    logic                  dout_vld_next;
    logic                  push;
    logic                  pop;
    logic                  load;
    logic [ADDR_WIDTH-1:0] rd_addr;

    assign if_full_n         = (used != USED_MAX);
    assign if_empty_n        = dout_vld;
    assign if_num_data_valid = {1'b0, used} + (ADDR_WIDTH+1)'(dout_vld);
    assign rd_addr           = used - ADDR_WIDTH'(1);

    // Handshakes and the refill decision; clk_en low suppresses every event
    always_comb begin
        push          = clk_en & if_write & if_full_n;
        pop           = clk_en & if_read & dout_vld;
        load          = clk_en & (used != '0) & (~dout_vld | pop);
        used_next     = used;
        dout_vld_next = load | (dout_vld & ~pop);
        case ({push, load})
            2'b10:   used_next = used + ADDR_WIDTH'(1);
            2'b01:   used_next = used - ADDR_WIDTH'(1);
            default: used_next = used;
        endcase
    end

    // Occupancy and head-valid registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            used     <= '0;
            dout_vld <= 1'b0;
        end else begin
            used     <= used_next;
            dout_vld <= dout_vld_next;
        end
    end

    kernel3_gmem_a_m_axi_srl #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (DEPTH)
    ) u_srl (
        .clk     (clk),
        .reset_n (reset_n),
        .shift_en(push),
        .din     (if_din),
        .rd_en   (load),
        .rd_addr (rd_addr),
        .q       (if_dout)
    );

endmodule

// File: tb/tb_kernel3_gmem_a_m_axi_srl_fifo.sv
// Self-checking bench for kernel3_gmem_a_m_axi_srl_fifo: directed vector table,
// fill/drain, streaming, clk_en hold, async reset pulse and random traffic
// checked against a queue-based model.

module tb_kernel3_gmem_a_m_axi_srl_fifo;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int DEPTH = 63;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clk_en;
    logic          if_full_n;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_empty_n;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic [AW:0]   if_num_data_valid;

    int total = 0;
    int bad   = 0;

    // Reference model: words waiting behind the head, plus the visible head
    logic [DW-1:0] storeQ [$];
    bit            headVld;
    logic [DW-1:0] headWord;

    typedef struct {
        bit            w;
        bit            r;
        bit            en;
        logic [DW-1:0] din;
        bit            expFull;
        bit            expEmpty;
        logic [DW-1:0] expDout;
        int            expCnt;
    } vec_t;

    vec_t vecs [9];

    always #5 clk = ~clk;

    kernel3_gmem_a_m_axi_srl_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .clk_en           (clk_en),
        .if_full_n        (if_full_n),
        .if_write         (if_write),
        .if_din           (if_din),
        .if_empty_n       (if_empty_n),
        .if_read          (if_read),
        .if_dout          (if_dout),
        .if_num_data_valid(if_num_data_valid)
    );

    task automatic checkOne(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input bit expFull, input bit expEmpty,
                               input logic [DW-1:0] expDout, input int expCnt);
        checkOne({tag, " full_n"},  DW'(if_full_n),  DW'(expFull));
        checkOne({tag, " empty_n"}, DW'(if_empty_n), DW'(expEmpty));
        checkOne({tag, " dout"},    if_dout,         expDout);
        checkOne({tag, " count"},   DW'(if_num_data_valid), DW'(expCnt));
    endtask

    function automatic int modelCount();
        return storeQ.size() + (headVld ? 1 : 0);
    endfunction

    task automatic checkModel(input string tag);
        checkOutput(tag, storeQ.size() != DEPTH - 1, headVld, headWord, modelCount());
    endtask

    task automatic modelReset();
        storeQ.delete();
        headVld  = 1'b0;
        headWord = '0;
    endtask

    task automatic modelStep(input bit w, input bit r, input bit en, input logic [DW-1:0] d);
        bit doPush;
        bit doPop;
        bit doLoad;
        doPush = en && w && (storeQ.size() != DEPTH - 1);
        doPop  = en && r && headVld;
        doLoad = en && (storeQ.size() > 0) && (!headVld || doPop);
        if (doLoad) begin
            headWord = storeQ.pop_front();
            headVld  = 1'b1;
        end else if (doPop) begin
            headVld = 1'b0;
        end
        if (doPush) storeQ.push_back(d);
    endtask

    task automatic applyStimulus(input bit w, input bit r, input bit en, input logic [DW-1:0] d);
        if_write = w;
        if_read  = r;
        clk_en   = en;
        if_din   = d;
        modelStep(w, r, en, d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int expIdx;
        logic [DW-1:0] seqIn;

        vecs[0] = '{1, 0, 1, 32'hA5A5_0001, 1, 0, 32'h0,         1};
        vecs[1] = '{0, 0, 1, 32'h0,         1, 1, 32'hA5A5_0001, 1};
        vecs[2] = '{0, 1, 1, 32'h0,         1, 0, 32'hA5A5_0001, 0};
        vecs[3] = '{0, 1, 1, 32'h0,         1, 0, 32'hA5A5_0001, 0};
        vecs[4] = '{1, 1, 1, 32'h11,        1, 0, 32'hA5A5_0001, 1};
        vecs[5] = '{1, 1, 1, 32'h22,        1, 1, 32'h11,        2};
        vecs[6] = '{1, 1, 0, 32'h33,        1, 1, 32'h11,        2};
        vecs[7] = '{0, 1, 1, 32'h0,         1, 1, 32'h22,        1};
        vecs[8] = '{0, 1, 1, 32'h0,         1, 0, 32'h22,        0};

        // Reset held with a write request pending
        reset_n  = 1'b0;
        clk_en   = 1'b1;
        if_write = 1'b1;
        if_read  = 1'b0;
        if_din   = 32'hDEAD_BEEF;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", 1'b1, 1'b0, 32'h0, 0);
        if_write = 1'b0;
        reset_n  = 1'b1;
        applyStimulus(0, 0, 1, 32'h0);
        checkOutput("post-reset idle", 1'b1, 1'b0, 32'h0, 0);

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].w, vecs[i].r, vecs[i].en, vecs[i].din);
            checkOutput($sformatf("vec%0d", i), vecs[i].expFull, vecs[i].expEmpty,
                        vecs[i].expDout, vecs[i].expCnt);
        end

        // Fill to capacity, then an extra write that must be dropped
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 0, 1, DW'(i));
            checkModel("fill");
        end
        checkOutput("full", 1'b0, 1'b1, 32'h0, DEPTH);
        applyStimulus(1, 0, 1, 32'hFFFF);
        checkOutput("write at full", 1'b0, 1'b1, 32'h0, DEPTH);

        // Drain and confirm order
        expIdx = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            if (if_empty_n) begin
                checkOne("drain order", if_dout, DW'(expIdx));
                expIdx++;
            end
            applyStimulus(0, 1, 1, 32'h0);
            checkModel("drain");
        end
        checkOne("drain words", DW'(expIdx), DW'(DEPTH));

        // Streaming with a clk_en hold in the middle
        seqIn = 32'h1000;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 1, seqIn);
            seqIn++;
        end
        checkOutput("prefill", 1'b1, 1'b1, 32'h1000, 5);
        for (int i = 0; i < 200; i++) begin
            bit en;
            en = !(i >= 100 && i < 110);
            applyStimulus(1, 1, en, seqIn);
            if (en) seqIn++;
            checkModel("stream");
            checkOne("stream count", DW'(if_num_data_valid), 32'd5);
        end

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            applyStimulus($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                          $urandom_range(0, 99) < 90, $urandom);
            checkModel("random");
        end

        // Bring occupancy to 20 words, bounded
        for (int i = 0; i < 200 && modelCount() != 20; i++) begin
            if (modelCount() < 20) applyStimulus(1, 0, 1, $urandom);
            else                   applyStimulus(0, 1, 1, 32'h0);
            checkModel("settle");
        end
        checkOne("settle count", DW'(if_num_data_valid), 32'd20);

        // Async reset pulse between edges
        if_write = 1'b1;
        if_read  = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async reset", 1'b1, 1'b0, 32'h0, 0);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 45,
                          $urandom_range(0, 99) < 90, $urandom);
            checkModel("after reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kernel3_gmem_a_m_axi_srl_fifo.md
# kernel3_gmem_A_m_axi_srl_fifo

Ready/valid FIFO controller for the gmem_A m_axi adapter, wrapping the shift-register storage primitive (kernel3_gmem_A_m_axi_srl) as its read-side manager. It accepts words from the upstream stage through a write handshake and presents them in order through a show-ahead read port. The controller tracks occupancy, generates the storage read address and read enable, and drives full/empty flags. It sits between the m_axi read/write request logic and the kernel-side streams.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 6, storage address width; DEPTH ≤ 2^ADDR_WIDTH − 1 required
- DEPTH, 63, total capacity in words (DEPTH−1 shift entries + 1 output register); DEPTH ≥ 3 required
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- clk_en  in  1  global enable; low freezes all state
- if_full_n  out  1  high = write accepted this cycle
- if_write  in  1  write request
- if_din  in  DATA_WIDTH  write data
- if_empty_n  out  1  high = if_dout valid
- if_read  in  1  read request (consumes if_dout)
- if_dout  out  DATA_WIDTH  head word
- if_num_data_valid  out  ADDR_WIDTH+1  words held (shift entries + output register)

## Operation
- push = clk_en & if_write & if_full_n; pop = clk_en & if_read & if_empty_n.
- State: used (0..DEPTH−1, words in shift storage), dout_vld (output register occupied), dout register.
- Push: din shifts into entry 0, older entries move up one; storage contents are not reset.
- Load: load = clk_en & (used ≠ 0) & (!dout_vld | pop); reads entry used−1 (oldest) into dout. Read index taken from pre-edge used; simultaneous shift does not corrupt it (registered read of pre-shift array).
- used_next = used + push − load; dout_vld_next = load | (dout_vld & !pop).
- if_full_n = (used ≠ DEPTH−1); if_empty_n = dout_vld; if_dout = dout; if_num_data_valid = used + dout_vld. All outputs decoded from registers only; no input-to-output combinational path.
- Write while full, read while empty: ignored, no state change.
- clk_en low: no push, pop, load or counter update regardless of if_write/if_read.

## Timing
- Reset (async assert, any time): used=0, dout_vld=0, dout=0; outputs immediately if_full_n=1, if_empty_n=0, if_dout=0, if_num_data_valid=0. In-flight data discarded. Release is sampled synchronously; first push possible on the first edge with reset_n high.
- Write-to-read latency into empty FIFO: push at edge N → load at edge N+1 → if_empty_n=1, if_dout=word after edge N+1 (2 cycles).
- Back-to-back pops with used>0: if_empty_n stays high, new head every cycle.
- Steady state push+pop each cycle with used ≥ 1: throughput 1 word/cycle, used constant.
- Full: from empty, 63 consecutive pushes (DEPTH=63, no pops) → used=62, dout_vld=1, if_full_n=0 after 63rd edge. A pop at full: load refills dout, used=61, if_full_n=1 next cycle.
- Push and pop at full in same cycle: push rejected (if_full_n=0 sampled), pop honoured.
- Empty with push+read same cycle: read ignored (if_empty_n=0); word appears 2 cycles later.

## Test plan
- Reset: hold reset_n=0, drive if_write=1 → if_full_n=1, if_empty_n=0, if_dout=0, count=0; no write accepted.
- Single word: write 0xA5A5_0001 at edge N → if_empty_n=1, if_dout=0xA5A5_0001, count=1 after edge N+1; read → empty, count=0 next edge.
- Fill/drain: write 0..62 back-to-back → if_full_n=0 after 63rd, 64th write (0xFFFF) ignored, count=63; drain returns 0..62 in order, never 0xFFFF.
- Streaming: prefill 5 words, then push and pop every cycle for 200 cycles → count stays 5, outputs sequential, no bubbles.
- clk_en: mid-stream hold clk_en=0 for 10 cycles with if_write=if_read=1 → count, if_dout, flags unchanged; resume matches reference model.
- Async reset mid-operation: with 20 words held, pulse reset_n low between edges → flags and count clear immediately, subsequent write/read sequence matches fresh-reset model.
